fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the RV32I pipelined core, directly upstream of the decode stage and its main decoder. It holds the fetch PC and issues requests to instruction memory. Up to two requests may be in flight; returned words are buffered in a 2-entry FIFO. It presents {instr_d, pc_d, pc_plus4_d, valid_d} to decode, honours stalls, and applies redirects on taken branches and jumps.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register.
// Up to two requests are outstanding and returned words are buffered in a 2-entry FIFO.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_sel,
  input  logic [31:0] target_pc,
  input  logic        if_flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] r_pc_f;
  logic [1:0]  r_inflight;
  logic [1:0]  r_discard_cnt;
  logic [31:0] r_tag_pc [2];
  logic        r_tag_rd;
  logic        r_tag_wr;
  logic [31:0] r_fifo_instr [2];
  logic [31:0] r_fifo_pc [2];
  logic        r_fifo_rd;
  logic        r_fifo_wr;
  logic [1:0]  r_fifo_cnt;
  logic        r_valid_d;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;

  logic [2:0]  w_credit_used;
  logic        w_req;
  logic        w_grant;
  logic [31:0] w_target;
  logic [31:0] w_resp_pc;
  logic        w_live;
  logic        w_load;
  logic        w_fifo_empty;
  logic        w_load_fifo;
  logic        w_bypass;
  logic        w_push;

  // Credit counts discarded-but-outstanding requests too, so the FIFO can never overflow.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_fifo_cnt};
  assign w_req         = !reset && !pc_sel && (w_credit_used < 3'(FIFO_DEPTH));
  assign w_grant       = w_req && imem_gnt;
  assign w_target      = target_pc & 32'hFFFF_FFFC;
  assign w_resp_pc     = r_tag_pc[r_tag_rd];
  assign w_live        = imem_rvalid && (r_discard_cnt == 2'd0) && !pc_sel;
  assign w_load        = !pc_sel && !if_flush && !stall;
  assign w_fifo_empty  = (r_fifo_cnt == 2'd0);
  assign w_load_fifo   = w_load && !w_fifo_empty;
  assign w_bypass      = w_load && w_fifo_empty && w_live;
  assign w_push        = w_live && !w_bypass;

  // NOTE: state uses non-blocking <= so every register sees pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f        <= RESET_PC;
      r_inflight    <= 2'd0;
      r_discard_cnt <= 2'd0;
      r_tag_rd      <= 1'b0;
      r_tag_wr      <= 1'b0;
    end else begin
      if (w_grant)     r_tag_wr <= ~r_tag_wr;
      if (imem_rvalid) r_tag_rd <= ~r_tag_rd;
      r_inflight <= r_inflight + 2'(w_grant) - 2'(imem_rvalid);
      if (pc_sel) begin
        r_pc_f        <= w_target;
        r_discard_cnt <= r_inflight - 2'(imem_rvalid);
      end else begin
        if (w_grant) r_pc_f <= r_pc_f + 32'd4;
        if (imem_rvalid && (r_discard_cnt != 2'd0)) r_discard_cnt <= r_discard_cnt - 2'd1;
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers and counts alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_grant) r_tag_pc[r_tag_wr] <= r_pc_f;
    if (w_push) begin
      r_fifo_instr[r_fifo_wr] <= imem_rdata;
      r_fifo_pc[r_fifo_wr]    <= w_resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || pc_sel) begin
      r_fifo_rd  <= 1'b0;
      r_fifo_wr  <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push)      r_fifo_wr <= ~r_fifo_wr;
      if (w_load_fifo) r_fifo_rd <= ~r_fifo_rd;
      r_fifo_cnt <= r_fifo_cnt + 2'(w_push) - 2'(w_load_fifo);
    end
  end

  // IF/ID register: buffered words take precedence over a same-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_d    <= 1'b0;
      r_instr_d    <= NOP;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
    end else if (pc_sel || if_flush) begin
      r_valid_d <= 1'b0;
    end else if (!stall) begin
      if (w_load_fifo) begin
        r_valid_d    <= 1'b1;
        r_instr_d    <= r_fifo_instr[r_fifo_rd];
        r_pc_d       <= r_fifo_pc[r_fifo_rd];
        r_pc_plus4_d <= r_fifo_pc[r_fifo_rd] + 32'd4;
      end else if (w_bypass) begin
        r_valid_d    <= 1'b1;
        r_instr_d    <= imem_rdata;
        r_pc_d       <= w_resp_pc;
        r_pc_plus4_d <= w_resp_pc + 32'd4;
      end else begin
        r_valid_d <= 1'b0;
      end
    end
  end

  assign imem_req   = w_req;
  assign imem_addr  = r_pc_f;
  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign valid_d    = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner-case sequences,
// then randomized traffic against a queue-based model of the fetch pipeline.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        pc_sel;
  logic [31:0] target_pc;
  logic        if_flush;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .pc_sel(pc_sel), .target_pc(target_pc),
    .if_flush(if_flush), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit          t_req;
  logic [31:0] t_addr;

  // Instruction memory: in-order responses, each due a per-request latency after its grant.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  // Reference model: outstanding requests flagged stale on redirect, FIFO of PCs, IF/ID contents.
  typedef struct { logic [31:0] pc; bit stale; } out_t;
  out_t        m_out[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_pc_d;
  logic [31:0] m_instr;

  typedef struct {
    bit          stall;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[11];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_load(input logic [31:0] p);
    m_valid = 1'b1;
    m_pc_d  = p;
    m_instr = mem_word(p);
  endtask

  task automatic model_edge();
    out_t e;
    bit   live;
    bit   req;
    if (reset) begin
      m_out.delete();
      m_fifo.delete();
      m_pc    = RESET_PC;
      m_valid = 1'b0;
      m_pc_d  = 32'd0;
      m_instr = NOP;
      return;
    end
    req  = !pc_sel && (m_out.size() + m_fifo.size() < 2);
    live = 1'b0;
    if (imem_rvalid) begin
      check("rvalid_has_inflight", 32'(m_out.size() != 0), 32'd1);
      if (m_out.size() != 0) begin
        e    = m_out.pop_front();
        live = !e.stale && !pc_sel;
      end
    end
    if (req && imem_gnt) begin
      m_out.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (pc_sel) begin
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      m_fifo.delete();
      m_valid = 1'b0;
      m_pc    = target_pc & ~32'h3;
    end else if (if_flush) begin
      m_valid = 1'b0;
      if (live) m_fifo.push_back(e.pc);
    end else if (stall) begin
      if (live) m_fifo.push_back(e.pc);
    end else if (m_fifo.size() > 0) begin
      model_load(m_fifo.pop_front());
      if (live) m_fifo.push_back(e.pc);
    end else if (live) begin
      model_load(e.pc);
    end else begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive the memory response, check request outputs, advance, check IF/ID.
  task automatic step();
    int due;
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    t_req  = imem_req;
    t_addr = imem_addr;
    check("imem_req", 32'(imem_req), 32'(!reset && !pc_sel && (m_out.size() + m_fifo.size() < 2)));
    if (!reset && !pc_sel && (m_out.size() + m_fifo.size() < 2)) check("imem_addr", imem_addr, m_pc);
    if (reset) begin
      mq.delete();
    end else if (imem_req && imem_gnt) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
      mq.push_back('{imem_addr, due});
    end
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check("valid_d", 32'(valid_d), 32'(m_valid));
    if (m_valid) begin
      check("pc_d", pc_d, m_pc_d);
      check("instr_d", instr_d, m_instr);
      check("pc_plus4_d", pc_plus4_d, m_pc_d + 32'd4);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_valid_d", 32'(valid_d), 32'd0);
    check("rst_instr_d", instr_d, NOP);
    check("rst_pc_d", pc_d, 32'd0);
    check("rst_pc_plus4_d", pc_plus4_d, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    logic [31:0] a0;
    logic [31:0] p0;

    vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
    vecs[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h08};
    vecs[6]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h08};
    vecs[7]  = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h0C};
    vecs[8]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10};
    vecs[9]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h14};
    vecs[10] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h18};

    reset = 1'b1; pc_sel = 1'b0; target_pc = 32'd0; if_flush = 1'b0; stall = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    @(posedge clk);
    #1;

    // Reset, then single-cycle streaming with a 3-cycle stall.
    step();
    step();
    check_reset_vals();
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      stall = vecs[i].stall;
      step();
      check($sformatf("vec%0d_req", i), 32'(t_req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d_addr", i), t_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), 32'(valid_d), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_pc", i), pc_d, vecs[i].exp_pc);
    end
    stall = 1'b0;

    // Latency 2: redirect to 0x103 while two requests are outstanding.
    lat_min = 2; lat_max = 2;
    for (int k = 0; k < 12 && m_out.size() != 2; k++) step();
    if (m_out.size() != 2) check("redirect_setup_timeout", 32'd0, 32'd1);
    pc_sel = 1'b1; target_pc = 32'h0000_0103;
    step();
    pc_sel = 1'b0;
    check("redirect_pc_f", imem_addr, 32'h0000_0100);
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (valid_d) begin found = 1'b1; break; end
    end
    check("redirect_valid_seen", 32'(found), 32'd1);
    check("redirect_first_pc", pc_d, 32'h0000_0100);

    // Grant withheld for 4 cycles: address must hold and nothing is re-fetched.
    imem_gnt = 1'b0;
    a0 = imem_addr;
    for (int k = 0; k < 4; k++) begin
      step();
      check("gnt_low_addr_hold", imem_addr, a0);
    end
    imem_gnt = 1'b1;
    for (int k = 0; k < 8; k++) step();

    // if_flush together with stall squashes IF/ID; the buffered successor follows.
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (m_valid) begin found = 1'b1; break; end
    end
    check("flush_setup_valid", 32'(found), 32'd1);
    p0 = m_pc_d;
    stall = 1'b1;
    for (int k = 0; k < 6 && m_fifo.size() == 0; k++) step();
    if (m_fifo.size() == 0) check("flush_setup_fifo_timeout", 32'd0, 32'd1);
    check("stall_hold_pc", pc_d, p0);
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    check("flush_valid_low", 32'(valid_d), 32'd0);
    stall = 1'b0;
    step();
    check("flush_next_valid", 32'(valid_d), 32'd1);
    check("flush_next_pc", pc_d, p0 + 32'd4);

    // Redirect to the top of the address space, then reset mid-stream.
    imem_gnt = 1'b0;
    step();
    step();
    imem_gnt = 1'b1;
    pc_sel = 1'b1; target_pc = 32'hFFFF_FFFC;
    step();
    pc_sel = 1'b0;
    step();
    check("wrap_first_grant", 32'(t_req), 32'd1);
    check("wrap_next_addr", imem_addr, 32'h0000_0000);
    step();
    check("wrap_valid", 32'(valid_d), 32'd1);
    check("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    check("wrap_pc_plus4_d", pc_plus4_d, 32'h0000_0000);
    reset = 1'b1;
    step();
    check_reset_vals();
    reset = 1'b0;
    #1;
    check("post_reset_addr", imem_addr, RESET_PC);
    check("post_reset_req", 32'(imem_req), 32'd1);

    // Randomized traffic with variable latency.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(199) == 0);
      pc_sel    = ($urandom_range(99) < 6);
      target_pc = $urandom;
      if_flush  = ($urandom_range(99) < 5);
      stall     = ($urandom_range(99) < 25);
      imem_gnt  = ($urandom_range(99) < 75);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
